axis_atomic_fi_sched: RTL and testbench
=======================================

Name: axis_atomic_fi_sched

Overview:
- Coalescing scheduler in front of the two-channel atomic fan-out path.
- Collects beats from two independent AXI-Stream requesters (cha, chb) and packs them into one combined word, with a 2-bit per-channel valid mask in tuser.
- Holds a lone beat for a programmable window so that beats from both channels leave together where possible.
- Sits between the channel producers and the combined atomic stream consumer.

Parameters:
- CHA_BITS, 8, width of channel A data
- CHB_BITS, 8, width of channel B data
- WAIT_BITS, 4, width of the coalescing window counter / cfg_wait

Ports:
- s_ul_clk  in  1  clock; all logic on rising edge
- resetn  in  1  synchronous reset, active-low
- cfg_wait  in  WAIT_BITS  coalescing window in cycles; 0 = no wait
- s_axis_cha_tready  out  1  channel A ready
- s_axis_cha_tvalid  in  1  channel A valid
- s_axis_cha_tdata  in  CHA_BITS  channel A data
- s_axis_chb_tready  out  1  channel B ready
- s_axis_chb_tvalid  in  1  channel B valid
- s_axis_chb_tdata  in  CHB_BITS  channel B data
- m_axis_comb_tready  in  1  combined stream ready
- m_axis_comb_tvalid  out  1  combined stream valid
- m_axis_comb_tdata  out  CHA_BITS+CHB_BITS  {B data, A data}; A in the LSBs
- m_axis_comb_tuser  out  2  [0] = A present, [1] = B present

Behaviour:
- State: one holding register per channel (data + full flag); FSM IDLE / WAIT / SEND; down-counter wcnt[WAIT_BITS-1:0].
- Reset (resetn=0 at a clock edge):
  - state=IDLE, both full flags=0, wcnt=0, m_axis_comb_tvalid=0.
  - Data registers are not reset.
  - Reset mid-operation discards held beats; no partial word is emitted.
- s_axis_chX_tready = ~fullX && state!=SEND. Combinational from registers only; no combinational path from any input valid.
- A beat is accepted when tvalid && tready. Data and the full flag are captured at that edge.
- IDLE:
  - Both accepted same cycle -> SEND.
  - One accepted and cfg_wait==0 -> SEND.
  - One accepted and cfg_wait!=0 -> WAIT, wcnt<=cfg_wait. cfg_wait is sampled only at this transition.
- WAIT:
  - Missing channel accepted -> SEND.
  - Else if wcnt==1 -> SEND (partial word).
  - Else wcnt<=wcnt-1.
  - An arrival in the same cycle as wcnt==1 is included: word is full, not partial.
- SEND:
  - m_axis_comb_tvalid=1; tdata = held data; tuser = {fullB, fullA}.
  - Output is stable until tready.
  - On tready: clear both full flags, go to IDLE.
  - No input accepted while in SEND.
- Latency:
  - First accept in cycle 0 -> m_axis_comb_tvalid in cycle 1 if the pair is complete or cfg_wait=0.
  - Lone beat -> tvalid in cycle cfg_wait+1.
  - Minimum throughput: 1 combined word per 2 cycles.
- Absent-channel bits of tdata hold stale data; the consumer uses tuser.
- A full channel never accepts a second beat; ordering within each channel is preserved.
- tuser is never 2'b00 while tvalid=1.

Optional Feature:
- Macro: AXIS_ATOMIC_FI_SCHED_STATS_EN
- Defined:
  - Adds outputs stat_pair_cnt[15:0] and stat_partial_cnt[15:0], both reset to 0.
  - At each combined handshake, increment stat_pair_cnt if tuser==2'b11, else stat_partial_cnt.
  - Both counters saturate at 16'hFFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset/idle: resetn=0 for 3 cycles, then resetn=1 with no input traffic -> tvalid=0, both treadys=1, no output for 20 cycles.
- Simultaneous pair: A=0x5A, B=0xC3 both valid in cycle 0, tready=1 -> cycle 1: tdata=0xC35A, tuser=2'b11; both treadys=0 in cycle 1, 1 in cycle 2.
- Coalesce: cfg_wait=4; A=0x11 in cycle 0; B=0x22 in cycle 3 -> cycle 4: tdata=0x2211, tuser=2'b11. Late arrival on the last window cycle (B in cycle 4) -> still tuser=2'b11, emitted in cycle 5.
- Timeout partial: cfg_wait=4; only B=0x7E in cycle 0 -> cycle 5: tuser=2'b10, tdata[15:8]=0x7E; s_axis_chb_tready=0 throughout.
- Backpressure: pair accepted, m_axis_comb_tready=0 for 6 cycles with A valid (0x33) -> output stable, s_axis_cha_tready=0; after tready, next word carries A=0x33.
- Stats (macro on): 3 pairs, 2 partials -> stat_pair_cnt=3, stat_partial_cnt=2; reset clears both.

Source files
------------

// File: rtl/axis_atomic_fi_sched.sv
// Coalescing scheduler: packs beats from two AXI-Stream channels into one
// combined word ({B,A} data, {B,A} present mask in tuser). A lone beat is
// held for up to cfg_wait cycles so that both channels can leave together.
//
// Ports:
//   s_ul_clk, resetn        clock, synchronous active-low reset
//   cfg_wait                coalescing window in cycles (0 = no wait)
//   s_axis_cha_*            channel A slave stream (tvalid/tready/tdata)
//   s_axis_chb_*            channel B slave stream (tvalid/tready/tdata)
//   m_axis_comb_*           combined master stream (tvalid/tready/tdata/tuser)
//   stat_pair_cnt           (AXIS_ATOMIC_FI_SCHED_STATS_EN) full-pair words sent
//   stat_partial_cnt        (AXIS_ATOMIC_FI_SCHED_STATS_EN) partial words sent
//
// Optional feature macro: AXIS_ATOMIC_FI_SCHED_STATS_EN

module axis_atomic_fi_sched #(
  parameter int CHA_BITS  = 8,
  parameter int CHB_BITS  = 8,
  parameter int WAIT_BITS = 4
) (
  input  logic                         s_ul_clk,
  input  logic                         resetn,
  input  logic [WAIT_BITS-1:0]         cfg_wait,
  output logic                         s_axis_cha_tready,
  input  logic                         s_axis_cha_tvalid,
  input  logic [CHA_BITS-1:0]          s_axis_cha_tdata,
  output logic                         s_axis_chb_tready,
  input  logic                         s_axis_chb_tvalid,
  input  logic [CHB_BITS-1:0]          s_axis_chb_tdata,
  input  logic                         m_axis_comb_tready,
  output logic                         m_axis_comb_tvalid,
  output logic [CHA_BITS+CHB_BITS-1:0] m_axis_comb_tdata,
  output logic [1:0]                   m_axis_comb_tuser
`ifdef AXIS_ATOMIC_FI_SCHED_STATS_EN
  ,
  output logic [15:0]                  stat_pair_cnt,
  output logic [15:0]                  stat_partial_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_full_a;
  logic                 r_full_b;
  logic                 r_tvalid;
  logic [WAIT_BITS-1:0] r_wcnt;
  logic [CHA_BITS-1:0]  r_dat_a;
  logic [CHB_BITS-1:0]  r_dat_b;

  logic w_rdy_a;
  logic w_rdy_b;
  logic w_acc_a;
  logic w_acc_b;
  logic w_hs;

  // Ready depends on registers only, never on the input valids.
  assign w_rdy_a = ~r_full_a & (r_state != ST_SEND);
  assign w_rdy_b = ~r_full_b & (r_state != ST_SEND);
  assign w_acc_a = s_axis_cha_tvalid & w_rdy_a;
  assign w_acc_b = s_axis_chb_tvalid & w_rdy_b;
  assign w_hs    = r_tvalid & m_axis_comb_tready;

  assign s_axis_cha_tready  = w_rdy_a;
  assign s_axis_chb_tready  = w_rdy_b;
  assign m_axis_comb_tvalid = r_tvalid;
  assign m_axis_comb_tdata  = {r_dat_b, r_dat_a};
  assign m_axis_comb_tuser  = {r_full_b, r_full_a};

  // Data holding registers carry no reset; tuser tells the consumer
  // which halves are meaningful.
  always_ff @(posedge s_ul_clk) begin
    if (w_acc_a) r_dat_a <= s_axis_cha_tdata;
    if (w_acc_b) r_dat_b <= s_axis_chb_tdata;
  end

  always_ff @(posedge s_ul_clk) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_full_a <= 1'b0;
      r_full_b <= 1'b0;
      r_wcnt   <= '0;
      r_tvalid <= 1'b0;
    end else begin
      if (w_acc_a) r_full_a <= 1'b1;
      if (w_acc_b) r_full_b <= 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (w_acc_a && w_acc_b) begin
            r_state  <= ST_SEND;
            r_tvalid <= 1'b1;
          end else if (w_acc_a || w_acc_b) begin
            if (cfg_wait == '0) begin
              r_state  <= ST_SEND;
              r_tvalid <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
              r_wcnt  <= cfg_wait;
            end
          end
        end
        ST_WAIT: begin
          // Only the missing channel can be ready here, so any accept
          // completes the pair, including one on the last window cycle.
          if (w_acc_a || w_acc_b) begin
            r_state  <= ST_SEND;
            r_tvalid <= 1'b1;
          end else if (r_wcnt <= WAIT_BITS'(1)) begin
            r_state  <= ST_SEND;
            r_tvalid <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt - WAIT_BITS'(1);
          end
        end
        ST_SEND: begin
          if (m_axis_comb_tready) begin
            r_state  <= ST_IDLE;
            r_tvalid <= 1'b0;
            r_full_a <= 1'b0;
            r_full_b <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_tvalid <= 1'b0;
          r_full_a <= 1'b0;
          r_full_b <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXIS_ATOMIC_FI_SCHED_STATS_EN
  logic [15:0] r_pair_cnt;
  logic [15:0] r_part_cnt;

  always_ff @(posedge s_ul_clk) begin
    if (!resetn) begin
      r_pair_cnt <= '0;
      r_part_cnt <= '0;
    end else if (w_hs) begin
      if (r_full_a && r_full_b) begin
        if (r_pair_cnt != 16'hFFFF) r_pair_cnt <= r_pair_cnt + 16'd1;
      end else begin
        if (r_part_cnt != 16'hFFFF) r_part_cnt <= r_part_cnt + 16'd1;
      end
    end
  end

  assign stat_pair_cnt    = r_pair_cnt;
  assign stat_partial_cnt = r_part_cnt;
`else
  logic w_unused;
  assign w_unused = w_hs;
`endif

endmodule

// File: tb/tb_axis_atomic_fi_sched.sv
// Self-checking bench for axis_atomic_fi_sched: directed vector table,
// hand-written corner sequences and a randomized run against a model.

module tb_axis_atomic_fi_sched;

  logic        clk;
  logic        resetn;
  logic [3:0]  cfg_wait;
  logic        a_rdy, a_vld;
  logic [7:0]  a_dat;
  logic        b_rdy, b_vld;
  logic [7:0]  b_dat;
  logic        m_rdy, m_vld;
  logic [15:0] m_dat;
  logic [1:0]  m_usr;
`ifdef AXIS_ATOMIC_FI_SCHED_STATS_EN
  logic [15:0] st_pair, st_part;
`endif

  int checks = 0;
  int failures = 0;

  axis_atomic_fi_sched dut (
    .s_ul_clk          (clk),
    .resetn            (resetn),
    .cfg_wait          (cfg_wait),
    .s_axis_cha_tready (a_rdy),
    .s_axis_cha_tvalid (a_vld),
    .s_axis_cha_tdata  (a_dat),
    .s_axis_chb_tready (b_rdy),
    .s_axis_chb_tvalid (b_vld),
    .s_axis_chb_tdata  (b_dat),
    .m_axis_comb_tready(m_rdy),
    .m_axis_comb_tvalid(m_vld),
    .m_axis_comb_tdata (m_dat),
    .m_axis_comb_tuser (m_usr)
`ifdef AXIS_ATOMIC_FI_SCHED_STATS_EN
    ,
    .stat_pair_cnt     (st_pair),
    .stat_partial_cnt  (st_part)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        av;
    bit [7:0]  ad;
    bit        bv;
    bit [7:0]  bd;
    bit        rdy;
    bit [3:0]  cw;
    bit        ev;
    bit [15:0] ed;
    bit [15:0] em;
    bit [1:0]  eu;
    bit        era;
    bit        erb;
  } vec_t;

  vec_t vec[22];

  // model state for the randomized run
  bit       mha, mhb, msend, had, ea, eb;
  bit [7:0] mda, mdb;
  int       deadline, cyc;
  bit       va, vb, rr;
  bit [7:0] da, db;
  bit [3:0] cw;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit av, input bit [7:0] ad, input bit bv,
                       input bit [7:0] bd, input bit r, input bit [3:0] w);
    a_vld = av; a_dat = ad;
    b_vld = bv; b_dat = bd;
    m_rdy = r;  cfg_wait = w;
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (n) step();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // vector table: inputs for one cycle, outputs after its edge
    vec[0]  = '{1, 8'h5A, 1, 8'hC3, 1, 0, 1, 16'hC35A, 16'hFFFF, 2'b11, 0, 0};
    vec[1]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 1};
    vec[2]  = '{1, 8'h11, 0, 8'h00, 1, 4, 0, 16'h0000, 16'h0000, 2'b00, 0, 1};
    vec[3]  = '{0, 8'h00, 0, 8'h00, 1, 1, 0, 16'h0000, 16'h0000, 2'b00, 0, 1};
    vec[4]  = '{0, 8'h00, 0, 8'h00, 1, 1, 0, 16'h0000, 16'h0000, 2'b00, 0, 1};
    vec[5]  = '{0, 8'h00, 1, 8'h22, 1, 4, 1, 16'h2211, 16'hFFFF, 2'b11, 0, 0};
    vec[6]  = '{0, 8'h00, 0, 8'h00, 1, 4, 0, 16'h0000, 16'h0000, 2'b00, 1, 1};
    vec[7]  = '{1, 8'h44, 0, 8'h00, 1, 4, 0, 16'h0000, 16'h0000, 2'b00, 0, 1};
    vec[8]  = '{0, 8'h00, 0, 8'h00, 1, 4, 0, 16'h0000, 16'h0000, 2'b00, 0, 1};
    vec[9]  = '{0, 8'h00, 0, 8'h00, 1, 4, 0, 16'h0000, 16'h0000, 2'b00, 0, 1};
    vec[10] = '{0, 8'h00, 0, 8'h00, 1, 4, 0, 16'h0000, 16'h0000, 2'b00, 0, 1};
    vec[11] = '{0, 8'h00, 1, 8'h55, 1, 4, 1, 16'h5544, 16'hFFFF, 2'b11, 0, 0};
    vec[12] = '{0, 8'h00, 0, 8'h00, 1, 4, 0, 16'h0000, 16'h0000, 2'b00, 1, 1};
    vec[13] = '{0, 8'h00, 1, 8'h7E, 1, 4, 0, 16'h0000, 16'h0000, 2'b00, 1, 0};
    vec[14] = '{0, 8'h00, 0, 8'h00, 1, 4, 0, 16'h0000, 16'h0000, 2'b00, 1, 0};
    vec[15] = '{0, 8'h00, 0, 8'h00, 1, 4, 0, 16'h0000, 16'h0000, 2'b00, 1, 0};
    vec[16] = '{0, 8'h00, 0, 8'h00, 1, 4, 0, 16'h0000, 16'h0000, 2'b00, 1, 0};
    vec[17] = '{0, 8'h00, 0, 8'h00, 1, 4, 1, 16'h7E00, 16'hFF00, 2'b10, 0, 0};
    vec[18] = '{0, 8'h00, 0, 8'h00, 0, 4, 1, 16'h7E00, 16'hFF00, 2'b10, 0, 0};
    vec[19] = '{0, 8'h00, 0, 8'h00, 1, 4, 0, 16'h0000, 16'h0000, 2'b00, 1, 1};
    vec[20] = '{1, 8'h99, 0, 8'h00, 1, 0, 1, 16'h0099, 16'h00FF, 2'b01, 0, 0};
    vec[21] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 1};

    // reset and idle
    do_reset(3);
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("idle_tvalid[%0d]", i), m_vld, 0);
      chk($sformatf("idle_rdya[%0d]", i), a_rdy, 1);
      chk($sformatf("idle_rdyb[%0d]", i), b_rdy, 1);
    end

    // directed table
    for (int i = 0; i < 22; i++) begin
      drive(vec[i].av, vec[i].ad, vec[i].bv, vec[i].bd, vec[i].rdy,
            vec[i].cw);
      step();
      chk($sformatf("vec%0d_tvalid", i), m_vld, vec[i].ev);
      chk($sformatf("vec%0d_rdya", i), a_rdy, vec[i].era);
      chk($sformatf("vec%0d_rdyb", i), b_rdy, vec[i].erb);
      if (vec[i].ev) begin
        chk($sformatf("vec%0d_tuser", i), m_usr, vec[i].eu);
        chk($sformatf("vec%0d_tdata", i), m_dat & vec[i].em, vec[i].ed);
      end
    end
`ifdef AXIS_ATOMIC_FI_SCHED_STATS_EN
    chk("stat_pair", st_pair, 3);
    chk("stat_part", st_part, 2);
`endif

    // backpressure with A waiting behind a stalled word
    drive(1, 8'h01, 1, 8'h02, 0, 0);
    step();
    chk("bp_tvalid0", m_vld, 1);
    chk("bp_tdata0", m_dat, 16'h0201);
    drive(1, 8'h33, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("bp_tvalid[%0d]", i), m_vld, 1);
      chk($sformatf("bp_tdata[%0d]", i), m_dat, 16'h0201);
      chk($sformatf("bp_tuser[%0d]", i), m_usr, 2'b11);
      chk($sformatf("bp_rdya[%0d]", i), a_rdy, 0);
    end
    m_rdy = 1'b1;
    step();
    chk("bp_release_tvalid", m_vld, 0);
    chk("bp_release_rdya", a_rdy, 1);
    step();
    chk("bp_next_tvalid", m_vld, 1);
    chk("bp_next_tuser", m_usr, 2'b01);
    chk("bp_next_tdata", m_dat[7:0], 8'h33);
    drive(0, 0, 0, 0, 1, 0);
    step();
    chk("bp_done_tvalid", m_vld, 0);

    // reset while a lone beat is waiting drops it
    drive(1, 8'h66, 0, 0, 1, 3);
    step();
    drive(0, 0, 0, 0, 1, 3);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
`ifdef AXIS_ATOMIC_FI_SCHED_STATS_EN
    chk("stat_pair_rst", st_pair, 0);
    chk("stat_part_rst", st_part, 0);
`endif
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rst_mid_tvalid[%0d]", i), m_vld, 0);
      chk($sformatf("rst_mid_rdya[%0d]", i), a_rdy, 1);
    end

    // randomized run against the model
    do_reset(2);
    mha = 0; mhb = 0; msend = 0; deadline = 0; cyc = 0;
    mda = 0; mdb = 0;
    va = 0; vb = 0; da = 0; db = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!va) begin
        va = ($urandom % 3) == 0;
        da = 8'($urandom);
      end
      if (!vb) begin
        vb = ($urandom % 3) == 0;
        db = 8'($urandom);
      end
      rr = ($urandom % 4) != 0;
      cw = 4'($urandom_range(0, 5));
      drive(va, da, vb, db, rr, cw);
      ea = va && !mha && !msend;
      eb = vb && !mhb && !msend;
      chk($sformatf("rnd%0d_rdya", n), a_rdy, !mha && !msend);
      chk($sformatf("rnd%0d_rdyb", n), b_rdy, !mhb && !msend);
      step();
      if (msend) begin
        if (rr) begin
          msend = 0; mha = 0; mhb = 0;
        end
      end else begin
        had = mha || mhb;
        if (ea) begin mha = 1; mda = da; end
        if (eb) begin mhb = 1; mdb = db; end
        if (mha && mhb) begin
          msend = 1;
        end else if (mha || mhb) begin
          if (!had) begin
            if (cw == 0) msend = 1;
            else deadline = cyc + int'(cw);
          end else if (cyc == deadline) begin
            msend = 1;
          end
        end
      end
      cyc++;
      if (ea) va = 0;
      if (eb) vb = 0;
      chk($sformatf("rnd%0d_tvalid", n), m_vld, msend);
      if (msend) begin
        chk($sformatf("rnd%0d_tuser", n), m_usr, {mhb, mha});
        if (mha) chk($sformatf("rnd%0d_da", n), m_dat[7:0], mda);
        if (mhb) chk($sformatf("rnd%0d_db", n), m_dat[15:8], mdb);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
